// File: rtl/adsr_pkg.sv
// Shared encodings and defaults for the ADSR envelope shaper.
package adsr_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH = 16;
  localparam int unsigned DEF_GAIN_WIDTH   = 8;
  localparam int unsigned DEF_RATE_WIDTH   = 14;
  localparam int unsigned DEF_EXP_SHIFT    = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  // Unity gain code for a given gain width.
  function automatic int unsigned gmax(input int unsigned gain_width);
    return (32'd1 << gain_width) - 32'd1;
  endfunction

endpackage

// File: rtl/env_rate_divider.sv
// Tick-rate divider: one step pulse every step_val ticks (0 behaves as 1).
module env_rate_divider #(
  parameter int unsigned RATE_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  clear,
  input  logic [RATE_WIDTH-1:0] step_val,
  output logic                  step_c
);

  logic [RATE_WIDTH-1:0] count;
  logic [RATE_WIDTH-1:0] last;

  always_comb begin
    last   = (step_val == '0) ? '0 : step_val - RATE_WIDTH'(1);
    step_c = tick && !clear && (count >= last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count <= '0;
    else if (clear || step_c) count <= '0;
    else if (tick)            count <= count + RATE_WIDTH'(1);
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope: per-note programmable phase rates, linear/exponential
// decay and release, and a one-stage signed gain multiplier.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned GAIN_WIDTH   = DEF_GAIN_WIDTH,
  parameter int unsigned RATE_WIDTH   = DEF_RATE_WIDTH,
  parameter int unsigned EXP_SHIFT    = DEF_EXP_SHIFT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           note_start,
  input  logic                           note_release,
  input  logic        [RATE_WIDTH-1:0]   attack_step,
  input  logic        [RATE_WIDTH-1:0]   decay_step,
  input  logic        [RATE_WIDTH-1:0]   release_step,
  input  logic        [GAIN_WIDTH-1:0]   sustain_level,
  input  logic                           exp_mode,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_in_valid,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_out_valid,
  output logic        [GAIN_WIDTH-1:0]   gain,
  output logic        [2:0]              env_state,
  output logic                           busy
);

  localparam logic [GAIN_WIDTH-1:0] GMAX_G    = GAIN_WIDTH'(gmax(GAIN_WIDTH));
  localparam logic [GAIN_WIDTH-1:0] GMAX_M1   = GMAX_G - GAIN_WIDTH'(1);
  localparam int unsigned           PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 2;

  env_state_e              state, state_nx;
  logic [GAIN_WIDTH-1:0]   gain_nx;
  logic [RATE_WIDTH-1:0]   atk_q, dec_q, rel_q, rate_sel;
  logic [GAIN_WIDTH-1:0]   sus_q;
  logic                    exp_q;
  logic                    release_go, div_clear, step_c;
  logic [GAIN_WIDTH-1:0]   shifted, dec_amt;
  logic [GAIN_WIDTH:0]     diff;
  logic [GAIN_WIDTH:0]     gain_p1;
  logic signed [PROD_WIDTH-1:0] product, scaled;

  assign env_state = state;

  // Rate for the active phase; the divider is held clear when not ramping.
  always_comb begin
    rate_sel = '0;
    unique case (state)
      ST_ATTACK:  rate_sel = atk_q;
      ST_DECAY:   rate_sel = dec_q;
      ST_RELEASE: rate_sel = rel_q;
      default:    rate_sel = '0;
    endcase
    release_go = note_release && (state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN});
    div_clear  = note_start || release_go || (state inside {ST_IDLE, ST_SUSTAIN});
  end

  env_rate_divider #(.RATE_WIDTH(RATE_WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .clear    (div_clear),
    .step_val (rate_sel),
    .step_c   (step_c)
  );

  // Downward step size, with one extra bit on the subtraction to catch underflow.
  always_comb begin
    shifted = gain >> EXP_SHIFT;
    dec_amt = (exp_q && (shifted != '0)) ? shifted : GAIN_WIDTH'(1);
    diff    = {1'b0, gain} - {1'b0, dec_amt};
  end

  always_comb begin
    state_nx = state;
    gain_nx  = gain;
    if (note_start) begin
      state_nx = ST_ATTACK;
    end else if (release_go) begin
      state_nx = ST_RELEASE;
    end else begin
      unique case (state)
        ST_ATTACK: begin
          if (gain == GMAX_G) begin
            state_nx = ST_DECAY;
          end else if (step_c) begin
            gain_nx = gain + GAIN_WIDTH'(1);
            if (gain == GMAX_M1) state_nx = ST_DECAY;
          end
        end
        ST_DECAY: begin
          if (gain <= sus_q) begin
            gain_nx  = sus_q;
            state_nx = ST_SUSTAIN;
          end else if (step_c) begin
            if (diff[GAIN_WIDTH] || (diff[GAIN_WIDTH-1:0] <= sus_q)) begin
              gain_nx  = sus_q;
              state_nx = ST_SUSTAIN;
            end else begin
              gain_nx = diff[GAIN_WIDTH-1:0];
            end
          end
        end
        ST_RELEASE: begin
          if (gain == '0) begin
            state_nx = ST_IDLE;
          end else if (step_c) begin
            if (diff[GAIN_WIDTH] || (diff[GAIN_WIDTH-1:0] == '0)) begin
              gain_nx  = '0;
              state_nx = ST_IDLE;
            end else begin
              gain_nx = diff[GAIN_WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      gain  <= '0;
      busy  <= 1'b0;
      atk_q <= '0;
      dec_q <= '0;
      rel_q <= '0;
      sus_q <= '0;
      exp_q <= 1'b0;
    end else begin
      state <= state_nx;
      gain  <= gain_nx;
      busy  <= (state_nx != ST_IDLE);
      if (note_start) begin
        atk_q <= attack_step;
        dec_q <= decay_step;
        rel_q <= release_step;
        sus_q <= sustain_level;
        exp_q <= exp_mode;
      end
    end
  end

  // Scale by (gain+1)/2^GAIN_WIDTH so full gain passes samples through unchanged.
  always_comb begin
    gain_p1 = {1'b0, gain} + (GAIN_WIDTH + 1)'(1);
    product = PROD_WIDTH'(sample_in) * $signed(PROD_WIDTH'(gain_p1));
    scaled  = product >>> GAIN_WIDTH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= sample_in_valid;
      if (sample_in_valid) sample_out <= (gain == '0) ? '0 : SAMPLE_WIDTH'(scaled);
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: directed envelope scenarios plus randomized notes.
module tb_adsr_envelope;

  localparam int SW = 16;
  localparam int GW = 8;
  localparam int RW = 14;
  localparam int GMAX = (1 << GW) - 1;
  localparam int P_IDLE = 0, P_ATTACK = 1, P_DECAY = 2, P_SUSTAIN = 3, P_RELEASE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, note_start = 1'b0, note_release = 1'b0;
  logic exp_mode = 1'b0, sample_in_valid = 1'b0;
  logic [RW-1:0] attack_step = '0, decay_step = '0, release_step = '0;
  logic [GW-1:0] sustain_level = '0;
  logic signed [SW-1:0] sample_in = '0;
  logic signed [SW-1:0] sample_out;
  logic sample_out_valid, busy;
  logic [GW-1:0] gain;
  logic [2:0] env_state;

  always #5 clk = ~clk;

  adsr_envelope dut (
    .clk(clk), .reset(reset), .tick(tick),
    .note_start(note_start), .note_release(note_release),
    .attack_step(attack_step), .decay_step(decay_step), .release_step(release_step),
    .sustain_level(sustain_level), .exp_mode(exp_mode),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .gain(gain), .env_state(env_state), .busy(busy)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Reference envelope: phase, gain and ticks elapsed since the last step.
  int m_phase = P_IDLE, m_gain = 0, m_cnt = 0;
  int m_atk = 0, m_dec = 0, m_rel = 0, m_sus = 0;
  bit m_exp = 1'b0;
  int exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_env(input string name, input int g, input int st);
    check({name, "_gain"}, gain, g);
    check({name, "_state"}, env_state, st);
  endtask

  function automatic int step_amt(input int g);
    if (m_exp) return (g / 8 < 1) ? 1 : g / 8;
    return 1;
  endfunction

  // floor(s * (g+1) / 256), silenced at zero gain.
  function automatic int scale(input int g, input int s);
    longint p;
    if (g == 0) return 0;
    p = longint'(s) * longint'(g + 1);
    return int'(p >>> 8);
  endfunction

  // One clock: apply inputs at negedge, advance the model to match the next posedge.
  task automatic do_cycle(input bit ns, input bit nr, input bit tk, input bit siv, input int smp);
    int eff;
    bit stepped;
    @(negedge clk);
    note_start = ns; note_release = nr; tick = tk;
    sample_in_valid = siv; sample_in = SW'(smp);
    if (reset) begin
      if (siv) exp_q.push_back(scale(m_gain, smp));
      if (ns) begin
        m_atk = attack_step; m_dec = decay_step; m_rel = release_step;
        m_sus = sustain_level; m_exp = exp_mode;
        m_cnt = 0; m_phase = P_ATTACK;
      end else if (nr && (m_phase == P_ATTACK || m_phase == P_DECAY || m_phase == P_SUSTAIN)) begin
        m_cnt = 0; m_phase = P_RELEASE;
      end else begin
        stepped = 1'b0;
        if (tk && (m_phase == P_ATTACK || m_phase == P_DECAY || m_phase == P_RELEASE)) begin
          eff = (m_phase == P_ATTACK) ? m_atk : (m_phase == P_DECAY) ? m_dec : m_rel;
          if (eff == 0) eff = 1;
          m_cnt++;
          if (m_cnt >= eff) begin stepped = 1'b1; m_cnt = 0; end
        end
        case (m_phase)
          P_ATTACK:
            if (m_gain == GMAX) m_phase = P_DECAY;
            else if (stepped) begin
              m_gain++;
              if (m_gain == GMAX) m_phase = P_DECAY;
            end
          P_DECAY:
            if (m_gain <= m_sus) begin m_gain = m_sus; m_phase = P_SUSTAIN; end
            else if (stepped) begin
              m_gain = m_gain - step_amt(m_gain);
              if (m_gain <= m_sus) begin m_gain = m_sus; m_phase = P_SUSTAIN; end
            end
          P_RELEASE:
            if (m_gain == 0) m_phase = P_IDLE;
            else if (stepped) begin
              m_gain = m_gain - step_amt(m_gain);
              if (m_gain <= 0) begin m_gain = 0; m_phase = P_IDLE; end
            end
          default: ;
        endcase
      end
    end
    @(posedge clk); #1;
    note_start = 1'b0; note_release = 1'b0; tick = 1'b0; sample_in_valid = 1'b0;
  endtask

  task automatic rnd_cycle(input bit ns, input bit nr, input bit tk);
    do_cycle(ns, nr, tk, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768);
  endtask

  task automatic run_ticks(input int n, input int spacing);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < spacing; j++) rnd_cycle(1'b0, 1'b0, j == 0);
  endtask

  task automatic program_note(input int atk, input int dec, input int rel, input int sus, input bit ex);
    attack_step = RW'(atk); decay_step = RW'(dec); release_step = RW'(rel);
    sustain_level = GW'(sus); exp_mode = ex;
  endtask

  // Scoreboard monitor: envelope tracking every cycle, samples popped on valid.
  initial begin
    int e;
    forever begin
      @(posedge clk); #1;
      check("mon_gain", gain, m_gain);
      check("mon_state", env_state, m_phase);
      check("mon_busy", busy, m_phase != P_IDLE);
      check("mon_valid", sample_out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (sample_out_valid) check("mon_sample", sample_out, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[4] = '{175, 154, 135, 119};
    int r;

    // Power-up reset
    rnd_cycle(1'b1, 1'b0, 1'b1);
    rnd_cycle(1'b0, 1'b0, 1'b1);
    check_env("reset", 0, P_IDLE);
    check("reset_busy", busy, 0);
    check("reset_valid", sample_out_valid, 0);
    check("reset_sample", sample_out, 0);
    reset = 1'b1;

    // Basic linear envelope, tick every 4 clk
    program_note(1, 2, 3, 128, 1'b0);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    check_env("attack_start", 0, P_ATTACK);
    run_ticks(254, 4);
    check_env("attack_254", 254, P_ATTACK);
    run_ticks(1, 4);
    check_env("attack_top", 255, P_DECAY);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, -32768);
    check("scale_unity", sample_out, -32768);
    run_ticks(254, 4);
    check_env("sustain_reach", 128, P_SUSTAIN);
    run_ticks(5, 4);
    check_env("sustain_hold", 128, P_SUSTAIN);
    rnd_cycle(1'b0, 1'b1, 1'b0);
    check_env("release_enter", 128, P_RELEASE);
    run_ticks(3, 4);
    check_env("release_first", 127, P_RELEASE);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1000);
    check("scale_127", sample_out, 500);
    run_ticks(127 * 3, 4);
    check_env("release_end", 0, P_IDLE);
    check("release_end_busy", busy, 0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1234);
    check("scale_zero", sample_out, 0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
    check_env("release_in_idle", 0, P_IDLE);

    // Exponential release from 200, step value 0 used for attack/decay
    program_note(0, 0, 1, 200, 1'b1);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    run_ticks(255, 1);
    check_env("exp_attack_top", 255, P_DECAY);
    run_ticks(2, 1);
    check_env("exp_decay_clamp", 200, P_SUSTAIN);
    rnd_cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_ticks(1, 1);
      check_env($sformatf("exp_release_%0d", k), exp_seq[k], P_RELEASE);
    end
    for (int k = 0; k < 200 && env_state != 3'(P_IDLE); k++) run_ticks(1, 1);
    check_env("exp_release_end", 0, P_IDLE);

    // Retrigger during release at gain 60
    program_note(0, 0, 0, 100, 1'b0);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    run_ticks(255 + 155, 1);
    check_env("retrig_sustain", 100, P_SUSTAIN);
    rnd_cycle(1'b0, 1'b1, 1'b0);
    run_ticks(40, 1);
    check_env("retrig_release60", 60, P_RELEASE);
    program_note(2, 0, 0, 100, 1'b0);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    check_env("retrig_attack", 60, P_ATTACK);
    run_ticks(2, 1);
    check_env("retrig_step", 61, P_ATTACK);
    rnd_cycle(1'b0, 1'b0, 1'b1);
    rnd_cycle(1'b1, 1'b0, 1'b1);
    check_env("start_beats_step", 61, P_ATTACK);
    rnd_cycle(1'b1, 1'b1, 1'b0);
    check_env("start_beats_release", 61, P_ATTACK);

    // Sustain at full scale: DECAY exits the next clock
    program_note(0, 0, 0, 255, 1'b0);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    run_ticks(194, 1);
    check_env("sus255_decay", 255, P_DECAY);
    rnd_cycle(1'b0, 1'b0, 1'b0);
    check_env("sus255_sustain", 255, P_SUSTAIN);

    // Asynchronous reset in the middle of DECAY
    program_note(0, 5, 0, 10, 1'b0);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    rnd_cycle(1'b0, 1'b0, 1'b0);
    run_ticks(10, 1);
    check_env("pre_reset", 253, P_DECAY);
    #2;
    reset = 1'b0;
    m_phase = P_IDLE; m_gain = 0; m_cnt = 0;
    m_atk = 0; m_dec = 0; m_rel = 0; m_sus = 0; m_exp = 1'b0;
    exp_q.delete();
    #1;
    check_env("async_reset", 0, P_IDLE);
    check("async_reset_busy", busy, 0);
    check("async_reset_sample", sample_out, 0);
    check("async_reset_valid", sample_out_valid, 0);
    for (int k = 0; k < 3; k++) rnd_cycle(1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) rnd_cycle(1'b0, k[0], 1'b1);
    check_env("post_reset_idle", 0, P_IDLE);

    // Randomized notes, with programming inputs churning between note_starts
    for (int c = 0; c < 6000; c++) begin
      program_note($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      r = $urandom_range(0, 599);
      rnd_cycle(r == 0, (r == 1) || (r == 2), $urandom_range(0, 1) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Parametrised attack/decay/sustain/release envelope shaper. It is the successor to the fixed 1/8-step attack/decay dynamics stage.
- Sits between the note player/harmonics sample path and the codec conditioner.
- Per-note programmable rates, sustain level, and linear or exponential decay/release.
- A note-release event drives a true release phase. Retriggering ramps from the current gain, with no reset to zero.

Parameters:
SAMPLE_WIDTH, 16, signed audio sample width
GAIN_WIDTH, 8, envelope gain width; GMAX = 2^GAIN_WIDTH-1 = unity
RATE_WIDTH, 14, width of per-phase tick-count programming
EXP_SHIFT, 3, exponential-mode step = gain >> EXP_SHIFT (minimum 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  envelope-rate strobe, one clk wide (e.g. beat_generator output)
note_start  in  1  pulse; latch programming, enter ATTACK
note_release  in  1  pulse; enter RELEASE
attack_step  in  RATE_WIDTH  ticks per +1 gain in ATTACK
decay_step  in  RATE_WIDTH  ticks per gain step in DECAY
release_step  in  RATE_WIDTH  ticks per gain step in RELEASE
sustain_level  in  GAIN_WIDTH  SUSTAIN gain
exp_mode  in  1  0 = linear decay/release, 1 = exponential
sample_in  in  SAMPLE_WIDTH  signed input sample
sample_in_valid  in  1  sample_in qualifier
sample_out  out  SAMPLE_WIDTH  signed scaled sample
sample_out_valid  out  1  sample_out qualifier
gain  out  GAIN_WIDTH  current envelope gain
env_state  out  3  current phase
busy  out  1  env_state != IDLE

Behaviour:
- Reset (async, reset=0) clears all outputs and internal state:
  - env_state=IDLE, gain=0, sample_out=0, sample_out_valid=0, busy=0.
  - Tick counter=0 and latched programming=0.
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- note_start, sampled on any clk in any state:
  - Latches attack/decay/release_step, sustain_level and exp_mode.
  - Clears the tick counter and enters ATTACK.
  - gain is retained, so retriggers are click-free.
- If note_start and note_release occur in the same cycle, note_start wins.
- note_release:
  - In ATTACK, DECAY or SUSTAIN: clears the tick counter and enters RELEASE.
  - In IDLE or RELEASE: ignored.
- Rate divider:
  - Counts tick pulses only.
  - Emits a step when count == step-1, then clears.
  - A step value of 0 is treated as 1, i.e. a step every tick.
- ATTACK:
  - Each step: gain += 1, saturating at GMAX.
  - The cycle gain reaches GMAX, the next state is DECAY.
  - If ATTACK is entered with gain == GMAX, go to DECAY on the next clk.
- DECAY:
  - Each step: linear gain -= 1; exponential gain -= max(1, gain >> EXP_SHIFT).
  - Result is clamped to no lower than sustain_level.
  - At gain == sustain_level, go to SUSTAIN. If gain <= sustain_level on entry, set gain = sustain_level and go to SUSTAIN next clk.
- SUSTAIN: gain holds; the tick counter is idle.
- RELEASE:
  - Same step rule as DECAY, with a floor of 0.
  - At gain == 0, go to IDLE.
- Datapath:
  - Single registered stage; latency 1 clk from sample_in_valid to sample_out_valid.
  - sample_out = (sample_in * (gain+1)) >>> GAIN_WIDTH, computed signed at full product width, truncated toward -inf.
  - Exception: gain==0 forces sample_out = 0.
  - gain==GMAX gives sample_out = sample_in exactly.
  - The gain used is the registered gain in the same cycle as sample_in_valid.
  - sample_out holds its value when sample_in_valid is 0.
- Width rules:
  - Exponential step computed at GAIN_WIDTH.
  - Subtraction performed at GAIN_WIDTH+1 to detect underflow before clamping.
- Simultaneous tick-step and note_start: note_start takes priority, and the step is discarded.

Decomposition:
- Package adsr_pkg holds:
  - State encodings (IDLE..RELEASE).
  - GMAX computation.
  - Default parameter constants.
- Sub-module env_rate_divider (RATE_WIDTH): inputs tick, clear and step value; output step pulse.
- The FSM and multiplier stay in adsr_envelope.

Test Plan:
1. Basic envelope:
   - Stimulus: defaults; attack_step=1, decay_step=2, sustain=128, exp_mode=0; tick every 4 clk; note_start.
   - Response: gain reaches 255 after 255 ticks; reaches 128 after 254 further ticks; holds in SUSTAIN.
   - Then note_release: gain reaches 0 after 128*release_step ticks; env_state=IDLE; busy=0.
2. Scaling:
   - Stimulus: gain=255 with sample_in=-32768 → sample_out=-32768 one clk later.
   - gain=127 with sample_in=1000 → 500; gain=0 → 0.
3. Exponential release:
   - Stimulus: exp_mode=1, release from 200, release_step=1.
   - Response: gain sequence 200, 175, 154, 135, ...; the tail decrements by 1 to 0, then IDLE.
4. Retrigger:
   - Stimulus: note_start during RELEASE at gain=60.
   - Response: ATTACK begins from 60, not 0; note_start+note_release in the same clk → ATTACK.
5. Boundaries:
   - sustain=255 → DECAY exits to SUSTAIN the next clk; step=0 behaves as 1.
   - note_release in IDLE → no change.
6. Reset mid-operation:
   - Stimulus: drive reset low during DECAY, asynchronously, mid-clk.
   - Response: all outputs 0 immediately; after release of reset, stays IDLE until note_start.
